// File: rtl/pipeline_reg_pkg.sv
// Shared types for the pipeline_reg skid buffer.
// The state encoding counts the beats currently held.
package pipeline_reg_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } pipe_state_e;

endpackage

// File: rtl/pipeline_reg_if.sv
// Upstream and downstream ready/valid channels of pipeline_reg.
// A beat moves on a rising clk edge when its valid and ready are both 1.
// A producer holds valid and data steady until that edge, and never waits on ready before raising valid.
interface pipeline_reg_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data
    );
endinterface

// File: rtl/pipeline_reg.sv
// Two-entry ready/valid skid buffer.
// in_ready, out_valid and out_data all come straight from flops, so neither path is combinational.
module pipeline_reg
    import pipeline_reg_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                clk,
    input  logic                rst,
    pipeline_reg_if.slave       bus,
    output pipe_state_e         state
);

    pipe_state_e           state_q;
    logic                  in_ready_q;
    logic                  out_valid_q;
    logic [DATA_WIDTH-1:0] main_q;
    logic [DATA_WIDTH-1:0] skid_q;
    logic                  in_xfer;
    logic                  out_xfer;

    assign in_xfer  = bus.in_valid && in_ready_q;
    assign out_xfer = out_valid_q && bus.out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= EMPTY;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            main_q      <= '0;
            skid_q      <= '0;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (in_xfer) begin
                        main_q      <= bus.in_data;
                        out_valid_q <= 1'b1;
                        in_ready_q  <= 1'b1;
                        state_q     <= BUSY;
                    end
                end
                BUSY: begin
                    if (in_xfer && !out_xfer) begin
                        // Downstream stalled: park the new beat behind the one on display.
                        skid_q      <= bus.in_data;
                        in_ready_q  <= 1'b0;
                        out_valid_q <= 1'b1;
                        state_q     <= FULL;
                    end else if (in_xfer && out_xfer) begin
                        main_q      <= bus.in_data;
                        state_q     <= BUSY;
                    end else if (out_xfer) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= EMPTY;
                    end
                end
                FULL: begin
                    if (out_xfer) begin
                        main_q      <= skid_q;
                        in_ready_q  <= 1'b1;
                        out_valid_q <= 1'b1;
                        state_q     <= BUSY;
                    end
                end
                default: begin
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                    state_q     <= EMPTY;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = main_q;
    assign state         = state_q;

endmodule

// File: tb/tb_pipeline_reg.sv
// Directed and random checks of pipeline_reg against an in-order expected queue.
module tb_pipeline_reg;
    import pipeline_reg_pkg::*;

    localparam int W = 32;

    logic        clk;
    logic        rst;
    pipe_state_e state;
    int          total;
    int          bad;
    logic [W-1:0] exp_q[$];
    logic         hold_active;
    logic [W-1:0] hold_data;
    int           pops;

    pipeline_reg_if #(.DATA_WIDTH(W)) bus ();

    pipeline_reg #(.DATA_WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .bus   (bus.slave),
        .state (state)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle at the negedge, then just before the posedge score the transfers it will make.
    task automatic drive(input logic iv, input logic [W-1:0] id, input logic ordy);
        logic [W-1:0] e;
        @(negedge clk);
        bus.in_valid  = iv;
        bus.in_data   = id;
        bus.out_ready = ordy;
        #4;
        if (hold_active && bus.out_valid === 1'b1)
            chk("stable", bus.out_data, hold_data);
        if (bus.out_valid === 1'b1 && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                chk("underflow", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("sb_data", bus.out_data, e);
                pops++;
            end
        end
        if (iv && bus.in_ready === 1'b1)
            exp_q.push_back(id);
        hold_active = (bus.out_valid === 1'b1) && !ordy;
        hold_data   = bus.out_data;
    endtask

    initial begin
        int guard;
        total = 0;
        bad = 0;
        pops = 0;
        hold_active = 1'b0;
        hold_data = '0;
        bus.in_valid = 1'b0;
        bus.in_data = '0;
        bus.out_ready = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_out_data", bus.out_data, 32'd0);
        chk("rst_state", 32'(state), 32'(EMPTY));
        rst = 1'b0;

        // normal transfer, first beat right after reset release
        drive(1'b1, 32'hAAAA5555, 1'b1);
        drive(1'b0, 32'h0, 1'b1);
        chk("norm_valid", 32'(bus.out_valid), 32'd1);
        chk("norm_data", bus.out_data, 32'hAAAA5555);
        drive(1'b0, 32'h0, 1'b0);
        chk("norm_empty", 32'(state), 32'(EMPTY));
        chk("norm_valid0", 32'(bus.out_valid), 32'd0);
        chk("norm_hold", bus.out_data, 32'hAAAA5555);

        // backpressure
        drive(1'b1, 32'h12345678, 1'b0);
        chk("bp1_ready", 32'(bus.in_ready), 32'd1);
        drive(1'b1, 32'h12345678, 1'b0);
        chk("bp2_state", 32'(state), 32'(BUSY));
        chk("bp2_data", bus.out_data, 32'h12345678);
        drive(1'b1, 32'hDEADBEEF, 1'b0);
        chk("bp3_state", 32'(state), 32'(FULL));
        chk("bp3_ready", 32'(bus.in_ready), 32'd0);
        chk("bp3_data", bus.out_data, 32'h12345678);

        // drain
        drive(1'b0, 32'h0, 1'b1);
        chk("dr1_valid", 32'(bus.out_valid), 32'd1);
        drive(1'b0, 32'h0, 1'b1);
        chk("dr2_data", bus.out_data, 32'h12345678);
        drive(1'b0, 32'h0, 1'b0);
        chk("dr_valid0", 32'(bus.out_valid), 32'd0);
        chk("dr_ready1", 32'(bus.in_ready), 32'd1);
        chk("dr_qempty", 32'(exp_q.size()), 32'd0);

        // streaming
        for (int i = 1; i <= 16; i++) begin
            drive(1'b1, 32'(i), 1'b1);
            if (i > 1) begin
                chk("str_valid", 32'(bus.out_valid), 32'd1);
                chk("str_data", bus.out_data, 32'(i - 1));
            end
        end
        drive(1'b0, 32'h0, 1'b1);
        chk("str_last", bus.out_data, 32'd16);
        chk("str_qempty", 32'(exp_q.size()), 32'd0);

        // random stalls
        for (int i = 0; i < 1000; i++)
            drive(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)));
        guard = 0;
        while (exp_q.size() != 0 && guard < 20) begin
            drive(1'b0, $urandom, 1'b1);
            guard++;
        end
        chk("rnd_qempty", 32'(exp_q.size()), 32'd0);
        drive(1'b0, 32'h0, 1'b1);
        chk("rnd_idle", 32'(bus.out_valid), 32'd0);

        // asynchronous reset with two beats buffered
        drive(1'b1, 32'h11111111, 1'b0);
        drive(1'b1, 32'h22222222, 1'b0);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        chk("pre_rst_full", 32'(state), 32'(FULL));
        #2 rst = 1'b1;
        #1;
        chk("arst_valid", 32'(bus.out_valid), 32'd0);
        chk("arst_ready", 32'(bus.in_ready), 32'd1);
        chk("arst_data", bus.out_data, 32'd0);
        chk("arst_state", 32'(state), 32'(EMPTY));
        exp_q.delete();
        hold_active = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        drive(1'b1, 32'hCAFEF00D, 1'b0);
        drive(1'b0, 32'h0, 1'b1);
        chk("post_rst_data", bus.out_data, 32'hCAFEF00D);
        drive(1'b0, 32'h0, 1'b0);
        chk("post_rst_empty", 32'(state), 32'(EMPTY));
        chk("post_rst_q", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
